// File: rtl/sync_fifo_flags_pkg.sv
// Shared definitions for the sync FIFO family: read-mode encodings
// and pointer/count width helpers.
package sync_fifo_flags_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra wrap bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: one write port, and either a registered read
// port or a combinational head-of-queue read port.
module sync_fifo_mem
    import sync_fifo_flags_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 4,
    parameter int FWFT       = FIFO_STD,
    parameter int AW         = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign rd_data = mem[rd_addr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through and overflow/underflow pulses.
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 4,
    parameter int FWFT       = FIFO_STD,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic                        i_rd_en,
    output logic [DATA_WIDTH-1:0]       o_rd_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_almost_full,
    output logic                        o_almost_empty,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    localparam int AW = idx_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] AF = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE = CW'(AE_THRESH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH ||
            (FWFT != FIFO_STD && FWFT != FIFO_FWFT)) begin : g_bad_params
            $error("sync_fifo_flags: illegal parameter combination");
        end
    endgenerate

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_acc;
    logic          rd_acc;
    logic          overflow;
    logic          underflow;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Acceptance uses pre-edge flags, so a full FIFO never writes
    // through even when a read frees a slot in the same cycle.
    assign wr_acc = i_wr_en && !full && !i_rst;
    assign rd_acc = i_rd_en && !empty && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= i_wr_en && full;
            underflow <= i_rd_en && empty;
        end
    end

    sync_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FWFT       (FWFT),
        .AW         (AW)
    ) u_mem (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (i_wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (o_rd_data)
    );

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count >= AF);
    assign o_almost_empty = (count <= AE);
    assign o_count        = count;
    assign o_overflow     = overflow;
    assign o_underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a registered-read instance and
// a first-word-fall-through instance, checked with immediate assertions.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;

    logic       wr, rd;
    logic [3:0] wd;
    logic [3:0] rdata;
    logic       full, empty, afull, aempty, ovf, unf;
    logic [3:0] cnt;

    logic       fwr, frd;
    logic [3:0] fwd;
    logic [3:0] frdata;
    logic       ffull, fempty, fafull, faempty, fovf, funf;
    logic [3:0] fcnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DEPTH(8), .DATA_WIDTH(4), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)
    ) u_std (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr),
        .i_wr_data      (wd),
        .i_rd_en        (rd),
        .o_rd_data      (rdata),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (cnt),
        .o_overflow     (ovf),
        .o_underflow    (unf)
    );

    sync_fifo_flags #(
        .DEPTH(8), .DATA_WIDTH(4), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)
    ) u_fwft (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (fwr),
        .i_wr_data      (fwd),
        .i_rd_en        (frd),
        .o_rd_data      (frdata),
        .o_full         (ffull),
        .o_empty        (fempty),
        .o_almost_full  (fafull),
        .o_almost_empty (faempty),
        .o_count        (fcnt),
        .o_overflow     (fovf),
        .o_underflow    (funf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_std(input string tag, input int c, input logic e,
                           input logic f, input logic ae, input logic af);
        chk({tag, ".count"}, 32'(cnt), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".aempty"}, 32'(aempty), 32'(ae));
        chk({tag, ".afull"}, 32'(afull), 32'(af));
    endtask

    initial begin
        rst = 1'b1;
        wr = 1'b0; rd = 1'b0; wd = 4'h0;
        fwr = 1'b0; frd = 1'b0; fwd = 4'h0;
        cycle();

        chk_std("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset.ovf", 32'(ovf), 32'd0);
        chk("reset.unf", 32'(unf), 32'd0);
        chk("reset.rdata", 32'(rdata), 32'd0);
        chk("reset.fempty", 32'(fempty), 32'd1);
        chk("reset.fcount", 32'(fcnt), 32'd0);
        rst = 1'b0;

        fwr = 1'b1; fwd = 4'hA;
        cycle();
        fwr = 1'b0;
        chk("fwft.empty", 32'(fempty), 32'd0);
        chk("fwft.rdata", 32'(frdata), 32'hA);
        chk("fwft.count", 32'(fcnt), 32'd1);
        fwr = 1'b1; fwd = 4'hB;
        cycle();
        fwr = 1'b0;
        chk("fwft.head_kept", 32'(frdata), 32'hA);
        frd = 1'b1;
        cycle();
        chk("fwft.pop1", 32'(frdata), 32'hB);
        chk("fwft.pop1.count", 32'(fcnt), 32'd1);
        cycle();
        frd = 1'b0;
        chk("fwft.pop2.empty", 32'(fempty), 32'd1);
        chk("fwft.pop2.count", 32'(fcnt), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            wr = 1'b1; wd = 4'(i);
            cycle();
            chk_std($sformatf("fill%0d", i), i, 1'b0, i == 8,
                    i <= 2, i >= 6);
        end
        wd = 4'hF;
        cycle();
        wr = 1'b0;
        chk("ovf.pulse", 32'(ovf), 32'd1);
        chk("ovf.count", 32'(cnt), 32'd8);
        cycle();
        chk("ovf.clear", 32'(ovf), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            rd = 1'b1;
            cycle();
            chk($sformatf("drain%0d.data", i), 32'(rdata), 32'(i));
            chk($sformatf("drain%0d.count", i), 32'(cnt), 32'(8 - i));
        end
        cycle();
        rd = 1'b0;
        chk("unf.pulse", 32'(unf), 32'd1);
        chk("unf.hold", 32'(rdata), 32'h8);
        chk_std("unf", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        chk("unf.clear", 32'(unf), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            wr = 1'b1; wd = 4'(i);
            cycle();
        end
        chk("conc.start", 32'(cnt), 32'd4);
        rd = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wd = 4'(k + 4);
            cycle();
            chk($sformatf("conc%0d.data", k), 32'(rdata), 32'(k & 15));
            chk($sformatf("conc%0d.count", k), 32'(cnt), 32'd4);
        end
        wr = 1'b0;
        for (int k = 21; k <= 24; k++) begin
            cycle();
            chk($sformatf("tail%0d", k), 32'(rdata), 32'(k & 15));
        end
        chk("tail.empty", 32'(empty), 32'd1);

        wr = 1'b1; wd = 4'hC;
        cycle();
        wr = 1'b0;
        chk("wr_rd_empty.count", 32'(cnt), 32'd1);
        chk("wr_rd_empty.unf", 32'(unf), 32'd1);
        chk("wr_rd_empty.hold", 32'(rdata), 32'h8);
        cycle();
        rd = 1'b0;
        chk("wr_rd_empty.read", 32'(rdata), 32'hC);
        chk("wr_rd_empty.drain", 32'(cnt), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            wr = 1'b1; wd = 4'(i);
            cycle();
        end
        chk("refill.full", 32'(full), 32'd1);
        rd = 1'b1; wd = 4'hF;
        cycle();
        wr = 1'b0;
        chk("wr_rd_full.count", 32'(cnt), 32'd7);
        chk("wr_rd_full.ovf", 32'(ovf), 32'd1);
        chk("wr_rd_full.data", 32'(rdata), 32'h1);
        cycle();
        chk("wr_rd_full.next", 32'(rdata), 32'h2);
        cycle();
        rd = 1'b0;
        chk("pre_rst.count", 32'(cnt), 32'd5);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_std("midrst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midrst.ovf", 32'(ovf), 32'd0);
        chk("midrst.unf", 32'(unf), 32'd0);
        chk("midrst.rdata", 32'(rdata), 32'd0);

        wr = 1'b1; wd = 4'h9;
        cycle();
        wr = 1'b0;
        chk("post_rst.count", 32'(cnt), 32'd1);
        rd = 1'b1;
        cycle();
        rd = 1'b0;
        chk("post_rst.data", 32'(rdata), 32'h9);
        chk("post_rst.empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
